cc_receive: RTL and testbench

Serial byte receiver for the CC link, the far end of the CC serial transmitter. Samples the idle-high, 8N1-style line (start bit low, 8 data bits LSB first, stop bit high), writes each received byte into a dual-port RAM at an incrementing address, and pulses `DONE` when a full subframe of `SUBFRAME` bytes has been stored. Sits between the CC pin input and the subframe buffer consumed by the decoder side.

---
 rtl/cc_receive.sv | 227 ++++++++++++++++++++++
 tb/tb_cc_receive.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_receive.sv
// cc_receive: serial byte receiver for the CC link.
//
// Watches an idle-high line carrying 8N1 frames: a low start bit, eight data
// bits LSB first, then a high stop bit. Each good byte is written to a
// subframe buffer at an incrementing address. When SUBFRAME bytes have been
// stored, a DONE pulse is raised and the address wraps back to 0. A partial
// subframe that goes quiet for GAP_CYCLES idle cycles is abandoned, and the
// address restarts at 0.
//
// Ports
//   clock_i      system clock
//   reset_i      synchronous, active-high reset
//   enable_i     receiver enable; low returns to IDLE and clears byte count
//   rx_i         asynchronous serial line input, idle high
//   wraddress_o  buffer write address (byte index within subframe)
//   wrdata_o     buffer write data
//   wren_o       one-cycle write strobe per good byte
//   done_o       one-cycle pulse with the write of the last subframe byte
//   frame_err_o  one-cycle pulse when the stop bit is sampled low
//   timeout_o    one-cycle pulse when a partial subframe is abandoned
//   busy_o       high whenever the receiver is not in IDLE
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge; runs the gap timer
// START     | half-bit wait, then re-check the start bit (glitch filter)
// DATA      | sample 8 data bits, one per bit period, at mid-bit
// STOP      | sample the stop bit; write the byte or flag a framing error
// WAIT_HIGH | stop bit was low; wait for the line to return high

module cc_receive #(
   parameter int SUBFRAME   = 2048,
   parameter int BIT_CYCLES = 51,
   parameter int GAP_CYCLES = 1024
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        rx_i,
   output logic [11:0] wraddress_o,
   output logic [7:0]  wrdata_o,
   output logic        wren_o,
   output logic        done_o,
   output logic        frame_err_o,
   output logic        timeout_o,
   output logic        busy_o
);

   localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

   localparam logic [7:0]       HALF_M1 = 8'(BIT_CYCLES / 2 - 1);
   localparam logic [7:0]       BIT_M1  = 8'(BIT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_M1  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [12:0]      SUB_M1  = 13'(SUBFRAME - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, rx_s_q, rx_d_q;
   logic [7:0]       cnt_q, cnt_d;
   logic [2:0]       bitn_q, bitn_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [12:0]      byte_cnt_q, byte_cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [11:0]      wraddress_q, wraddress_d;
   logic [7:0]       wrdata_q, wrdata_d;
   logic             wren_q, wren_d;
   logic             done_q, done_d;
   logic             ferr_q, ferr_d;
   logic             tout_q, tout_d;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         // Synchronizer resets to the idle level so reset never looks like a start edge.
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_d_q      <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bitn_q      <= '0;
         shreg_q     <= '0;
         byte_cnt_q  <= '0;
         gap_q       <= '0;
         wraddress_q <= '0;
         wrdata_q    <= '0;
         wren_q      <= 1'b0;
         done_q      <= 1'b0;
         ferr_q      <= 1'b0;
         tout_q      <= 1'b0;
      end else begin
         sync1_q     <= rx_i;
         rx_s_q      <= sync1_q;
         rx_d_q      <= rx_s_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bitn_q      <= bitn_d;
         shreg_q     <= shreg_d;
         byte_cnt_q  <= byte_cnt_d;
         gap_q       <= gap_d;
         wraddress_q <= wraddress_d;
         wrdata_q    <= wrdata_d;
         wren_q      <= wren_d;
         done_q      <= done_d;
         ferr_q      <= ferr_d;
         tout_q      <= tout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitn_d      = bitn_q;
      shreg_d     = shreg_q;
      byte_cnt_d  = byte_cnt_q;
      gap_d       = gap_q;
      wraddress_d = wraddress_q;
      wrdata_d    = wrdata_q;
      wren_d      = 1'b0;
      done_d      = 1'b0;
      ferr_d      = 1'b0;
      tout_d      = 1'b0;

      if (!enable_i) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         bitn_d     = '0;
         byte_cnt_d = '0;
         gap_d      = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Gap timer only runs while a subframe is partially filled.
               if (byte_cnt_q != 13'd0) begin
                  if (gap_q == GAP_M1) begin
                     tout_d     = 1'b1;
                     byte_cnt_d = '0;
                     gap_d      = '0;
                  end else begin
                     gap_d = gap_q + GAP_W'(1);
                  end
               end
               if (rx_d_q && !rx_s_q) begin
                  state_d = S_START;
                  cnt_d   = '0;
                  gap_d   = '0;
               end
            end

            S_START: begin
               if (cnt_q == HALF_M1) begin
                  if (!rx_s_q) begin
                     state_d = S_DATA;
                     cnt_d   = '0;
                     bitn_d  = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end

            S_DATA: begin
               if (cnt_q == BIT_M1) begin
                  shreg_d = {rx_s_q, shreg_q[7:1]};
                  cnt_d   = '0;
                  bitn_d  = bitn_q + 3'd1;
                  if (bitn_q == 3'd7) begin
                     state_d = S_STOP;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end

            S_STOP: begin
               // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
               if (cnt_q == BIT_M1) begin
                  cnt_d = '0;
                  if (rx_s_q) begin
                     wren_d      = 1'b1;
                     wrdata_d    = shreg_q;
                     wraddress_d = byte_cnt_q[11:0];
                     if (byte_cnt_q == SUB_M1) begin
                        done_d     = 1'b1;
                        byte_cnt_d = '0;
                     end else begin
                        byte_cnt_d = byte_cnt_q + 13'd1;
                     end
                     state_d = S_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = S_WAIT_HIGH;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end

            S_WAIT_HIGH: begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign wraddress_o = wraddress_q;
   assign wrdata_o    = wrdata_q;
   assign wren_o      = wren_q;
   assign done_o      = done_q;
   assign frame_err_o = ferr_q;
   assign timeout_o   = tout_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cc_receive.sv
// Bench for cc_receive. The line is driven at pin level. A timeline model
// predicts the cycle and content of every write, frame_err and timeout pulse
// from the frame timing rules: the edge reaches rx_s after two flops, START is
// entered one cycle later, and the samples land at +BIT/2 and then at each
// bit period after that. One compare process checks every output on every cycle.
module tb_cc_receive;
   localparam int SUB  = 4;
   localparam int BIT  = 51;
   localparam int GAP  = 1024;
   localparam int HALF = BIT / 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic        rx  = 1'b1;
   logic [11:0] wraddress;
   logic [7:0]  wrdata;
   logic        wren, done, frame_err, timeout, busy;

   cc_receive #(.SUBFRAME(SUB), .BIT_CYCLES(BIT), .GAP_CYCLES(GAP)) dut (
      .clock_i(clk), .reset_i(rst), .enable_i(en), .rx_i(rx),
      .wraddress_o(wraddress), .wrdata_o(wrdata), .wren_o(wren),
      .done_o(done), .frame_err_o(frame_err), .timeout_o(timeout), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      bit          fe;
      logic [11:0] addr;
      logic [7:0]  data;
      bit          done;
   } ev_t;

   typedef struct {
      int          cyc;
      logic [11:0] addr;
      logic [7:0]  data;
      bit          done;
   } wr_t;

   ev_t wq[$];
   int  tq[$];
   wr_t wr_log[$];
   int  cnt_m = 0;
   int  n_wr_exp = 0, n_fe_exp = 0;
   int  ferr_cnt = 0, to_cnt = 0;
   int  checks = 0, errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- compare process ----------------
   initial begin
      logic [11:0] h_addr;
      logic [7:0]  h_data;
      bit          e_wr, e_done, e_fe, e_to;
      ev_t         ev;
      h_addr = '0;
      h_data = '0;
      forever begin
         @(posedge clk);
         #2;
         e_wr = 0; e_done = 0; e_fe = 0; e_to = 0;
         if (rst) begin
            h_addr = '0;
            h_data = '0;
         end else begin
            while (wq.size() > 0 && wq[0].cyc <= cyc) begin
               ev = wq.pop_front();
               chk("event_time", cyc, ev.cyc);
               if (ev.fe) e_fe = 1;
               else begin
                  e_wr   = 1;
                  e_done = ev.done;
                  h_addr = ev.addr;
                  h_data = ev.data;
               end
            end
            while (tq.size() > 0 && tq[0] <= cyc) begin
               chk("timeout_time", cyc, tq[0]);
               void'(tq.pop_front());
               e_to = 1;
            end
         end
         chk("wren", int'(wren), int'(e_wr));
         chk("done", int'(done), int'(e_done));
         chk("frame_err", int'(frame_err), int'(e_fe));
         chk("timeout", int'(timeout), int'(e_to));
         chk("wraddress", int'(wraddress), int'(h_addr));
         chk("wrdata", int'(wrdata), int'(h_data));
         if (wren) wr_log.push_back('{cyc, wraddress, wrdata, done});
         if (frame_err) ferr_cnt++;
         if (timeout) to_cnt++;
      end
   end

   // ---------------- model helpers ----------------
   // A start detected at edge s either cancels the pending abandon timer or,
   // if the timer expired at or before s, means the subframe was dropped.
   task automatic model_start(input int s);
      if (cnt_m != 0) begin
         if (tq.size() > 0 && tq[$] > s) tq.delete(tq.size() - 1);
         else cnt_m = 0;
      end
   endtask

   task automatic purge();
      while (wq.size() > 0 && wq[$].cyc > cyc) wq.delete(wq.size() - 1);
      while (tq.size() > 0 && tq[$] > cyc) tq.delete(tq.size() - 1);
   endtask

   task automatic abort_rx(input bit by_reset);
      rx = 1'b1;
      purge();
      cnt_m = 0;
      if (by_reset) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end else begin
         en = 1'b0;
         repeat (4) @(negedge clk);
         en = 1'b1;
      end
      repeat (10) @(negedge clk);
   endtask

   // good=0 holds the stop bit low for stop_len cycles (framing error).
   // abort_bit>=0 cuts the frame at that data bit by reset or enable.
   task automatic send_byte(input logic [7:0] b, input int start_len, input int stop_len,
                            input bit good, input int abort_bit, input bit abort_rst,
                            output int n0);
      int s, w;
      @(negedge clk);
      n0 = cyc;
      rx = 1'b0;
      s  = n0 + 3;
      model_start(s);
      w  = s + HALF + 9 * BIT;
      if (abort_bit < 0) begin
         if (good) begin
            wq.push_back('{w, 1'b0, 12'(cnt_m), b, (cnt_m == SUB - 1)});
            n_wr_exp++;
            cnt_m = (cnt_m + 1) % SUB;
            if (cnt_m != 0) tq.push_back(w + GAP);
         end else begin
            wq.push_back('{w, 1'b1, 12'd0, 8'd0, 1'b0});
            n_fe_exp++;
         end
      end
      repeat (start_len) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         if (k == abort_bit) begin
            abort_rx(abort_rst);
            return;
         end
         rx = b[k];
         repeat (BIT) @(negedge clk);
      end
      if (good) begin
         rx = 1'b1;
         repeat (stop_len) @(negedge clk);
      end else begin
         rx = 1'b0;
         repeat (stop_len) @(negedge clk);
         chk("busy_wait_high", int'(busy), 1);
         rx = 1'b1;
         if (cnt_m != 0) tq.push_back(cyc + 3 + GAP);
         repeat (30) @(negedge clk);
         chk("busy_after_high", int'(busy), 0);
      end
   endtask

   task automatic glitch(input int len);
      int s;
      @(negedge clk);
      s = cyc + 3;
      model_start(s);
      if (cnt_m != 0) tq.push_back(s + HALF + GAP);
      rx = 1'b0;
      repeat (len) @(negedge clk);
      rx = 1'b1;
      repeat (HALF + 10) @(negedge clk);
      chk("busy_after_glitch", int'(busy), 0);
   endtask

   task automatic chk_wr(input string nm, input int idx, input int addr, input int data, input int dn);
      if (idx >= wr_log.size()) chk({nm, "_present"}, wr_log.size(), idx + 1);
      else begin
         chk({nm, "_addr"}, int'(wr_log[idx].addr), addr);
         chk({nm, "_data"}, int'(wr_log[idx].data), data);
         chk({nm, "_done"}, int'(wr_log[idx].done), dn);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #800000;
      errors++;
      $display("FAIL watchdog: got cycle %0d expected completion", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n0, base, fe0, op, lim;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_wraddress", int'(wraddress), 0);
      chk("reset_wrdata", int'(wrdata), 0);

      // first byte: address 0, fixed pin-to-strobe latency
      send_byte(8'hA5, BIT, 2 * BIT, 1, -1, 0, n0);
      chk_wr("A5", 0, 0, 'hA5, 0);
      if (wr_log.size() > 0) chk("A5_latency", wr_log[0].cyc - n0, 487);
      send_byte(8'h3C, BIT, 2 * BIT, 1, -1, 0, n0);
      chk_wr("3C", 1, 1, 'h3C, 0);

      // idle past the gap limit abandons the two-byte subframe
      repeat (1100) @(negedge clk);
      chk("timeout_cnt", to_cnt, 1);

      // full subframe back-to-back with short stop bits
      base = wr_log.size();
      for (int i = 1; i <= 4; i++) send_byte(8'(i), BIT, 30, 1, -1, 0, n0);
      for (int i = 0; i < 4; i++) chk_wr("sub", base + i, i, i + 1, (i == 3) ? 1 : 0);
      send_byte(8'h55, BIT - 1, 60, 1, -1, 0, n0);
      chk_wr("55", base + 4, 0, 'h55, 0);

      // start glitch: nothing written or flagged
      base = wr_log.size();
      glitch(10);
      chk("glitch_writes", wr_log.size(), base);
      chk("glitch_ferr", ferr_cnt, 0);

      // stop bit held low: one frame error, no write, address unchanged
      send_byte(8'h81, BIT, 200, 0, -1, 0, n0);
      chk("ferr_cnt", ferr_cnt, 1);
      chk("ferr_writes", wr_log.size(), base);
      send_byte(8'h42, BIT, 40, 1, -1, 0, n0);
      chk_wr("42", base, 1, 'h42, 0);

      // reset in the middle of a byte
      base = wr_log.size();
      send_byte(8'hC3, BIT, 40, 1, 4, 1, n0);
      chk("rst_abort_writes", wr_log.size(), base);
      send_byte(8'h99, BIT, 40, 1, -1, 0, n0);
      chk_wr("99", base, 0, 'h99, 0);

      // enable dropped in the middle of a byte
      base = wr_log.size();
      send_byte(8'h10, BIT, 40, 1, 2, 0, n0);
      chk("en_abort_writes", wr_log.size(), base);
      send_byte(8'h77, BIT, 40, 1, -1, 0, n0);
      chk_wr("77", base, 0, 'h77, 0);

      // randomized traffic against the timeline model
      fe0 = ferr_cnt;
      for (int r = 0; r < 30; r++) begin
         op = $urandom_range(0, 9);
         if (op <= 5)
            send_byte(8'($urandom_range(0, 255)), BIT - $urandom_range(0, 1),
                      $urandom_range(30, 120), 1, -1, 0, n0);
         else if (op == 6) glitch($urandom_range(1, 20));
         else if (op == 7) send_byte(8'($urandom_range(0, 255)), BIT, $urandom_range(30, 200), 0, -1, 0, n0);
         else if (op == 8) repeat ($urandom_range(1030, 1300)) @(negedge clk);
         else repeat ($urandom_range(0, 200)) @(negedge clk);
      end

      // drain pending predictions
      lim = 0;
      while ((wq.size() > 0 || tq.size() > 0) && lim < 3000) begin
         @(negedge clk);
         lim++;
      end
      chk("drain_pending", wq.size() + tq.size(), 0);
      repeat (5) @(negedge clk);
      chk("total_writes", wr_log.size(), n_wr_exp);
      chk("total_ferr", ferr_cnt, n_fe_exp);
      chk("random_ferr", ferr_cnt - fe0, n_fe_exp - 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
